// File: rtl/fft_input_framer_if.sv
// fft_input_framer_if
//   Bundles the settings bus, the paced sample input and the FFT-side frame
//   output of fft_input_framer. Clock and reset stay plain ports on the block.
//   master : drives settings/sample/fft_rfd, observes frame outputs (testbench/system)
//   slave  : the framer itself
//   IDX_W must equal log2(FRAME_LEN) of the attached framer.
interface fft_input_framer_if #(
    parameter int IDX_W = 6
);
    logic             set_stb;
    logic [7:0]       set_addr;
    logic [31:0]      set_data;
    logic [31:0]      sample_in;
    logic             sample_stb;
    logic             fft_rfd;
    logic             fft_start;
    logic [31:0]      xn;
    logic             xn_dv;
    logic [IDX_W-1:0] xn_index;
    logic             xn_last;
    logic             overflow;
    logic [15:0]      ovf_count;

    modport master (
        output set_stb, set_addr, set_data, sample_in, sample_stb, fft_rfd,
        input  fft_start, xn, xn_dv, xn_index, xn_last, overflow, ovf_count
    );

    modport slave (
        input  set_stb, set_addr, set_data, sample_in, sample_stb, fft_rfd,
        output fft_start, xn, xn_dv, xn_index, xn_last, overflow, ovf_count
    );
endinterface

// File: rtl/fft_input_framer.sv
// fft_input_framer
//   Buffers a paced, strobed 32-bit sample stream in a FIFO and replays it to
//   an FFT core as gap-free frames of FRAME_LEN words, each announced by a
//   one-cycle fft_start pulse in the cycle before the first word.
// Ports
//   clock : system clock, rising edge
//   reset : asynchronous, active-high; clears all state and outputs
//   fif   : slave side of fft_input_framer_if
//           settings bus (set_stb/set_addr/set_data: bit0 enable, bit1 flush),
//           sample_in/sample_stb input stream, fft_rfd ready,
//           fft_start/xn/xn_dv/xn_index/xn_last frame output,
//           overflow (sticky) / ovf_count (saturating) drop statistics
module fft_input_framer #(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned DEPTH     = 256,
    parameter logic [7:0]  SR_ADDR   = 8'd1
) (
    input logic             clock,
    input logic             reset,
    fft_input_framer_if.slave fif
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] beat_q, beat_d;

    logic             enable_q;
    logic             flush_req_q;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             overflow_q;
    logic [15:0]      ovf_count_q;

    logic             fft_start_q;
    logic [31:0]      xn_q;
    logic             xn_dv_q;
    logic [IDX_W-1:0] xn_index_q;
    logic             xn_last_q;

    logic             ctrl_wr;
    logic             full;
    logic             pop;
    logic             do_flush;
    logic             push;
    logic             drop;
    logic             unused_set_data;

    assign ctrl_wr         = fif.set_stb && (fif.set_addr == SR_ADDR);
    assign full            = (count_q == CW'(DEPTH));
    assign unused_set_data = ^fif.set_data[31:2];

    // A flush empties the FIFO in the same cycle, so a sample arriving then is
    // neither stored nor counted as an overflow.
    assign push = fif.sample_stb && enable_q && !full && !do_flush;
    assign drop = fif.sample_stb && enable_q &&  full && !do_flush;

    // Frame sequencer
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        pop      = 1'b0;
        do_flush = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                // Flush wins over launching; the whole frame must already be
                // buffered so STREAM can pop every cycle without underflow.
                if (flush_req_q)
                    do_flush = 1'b1;
                else if (enable_q && fif.fft_rfd && count_q >= CW'(FRAME_LEN))
                    state_d = START;
            end
            START: begin
                beat_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                pop    = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_IDX)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Control register; a new write takes precedence over clearing the flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable_q    <= 1'b0;
            flush_req_q <= 1'b0;
        end else if (ctrl_wr) begin
            enable_q    <= fif.set_data[0];
            flush_req_q <= fif.set_data[1];
        end else if (do_flush) begin
            flush_req_q <= 1'b0;
        end
    end

    // FIFO storage (no reset needed: count_q qualifies all reads)
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr_q] <= fif.sample_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (do_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Drop statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            ovf_count_q <= '0;
        end else if (do_flush) begin
            overflow_q  <= 1'b0;
            ovf_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (ovf_count_q != 16'hFFFF)
                ovf_count_q <= ovf_count_q + 16'd1;
        end
    end

    // Output register. fft_start is registered from START so it lands in the
    // first STREAM cycle, exactly one cycle ahead of the first registered word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fft_start_q <= 1'b0;
            xn_q        <= '0;
            xn_dv_q     <= 1'b0;
            xn_index_q  <= '0;
            xn_last_q   <= 1'b0;
        end else begin
            fft_start_q <= (state_q == START);
            xn_dv_q     <= pop;
            xn_index_q  <= pop ? beat_q : '0;
            xn_last_q   <= pop && (beat_q == LAST_IDX);
            if (pop)
                xn_q <= mem[rd_ptr_q];
        end
    end

    assign fif.fft_start = fft_start_q;
    assign fif.xn        = xn_q;
    assign fif.xn_dv     = xn_dv_q;
    assign fif.xn_index  = xn_index_q;
    assign fif.xn_last   = xn_last_q;
    assign fif.overflow  = overflow_q;
    assign fif.ovf_count = ovf_count_q;
endmodule

// File: tb/tb_fft_input_framer.sv
module tb_fft_input_framer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    fft_input_framer_if #(.IDX_W(6)) bus ();

    fft_input_framer #(.FRAME_LEN(64), .DEPTH(256), .SR_ADDR(8'd1)) dut (
        .clock (clock),
        .reset (reset),
        .fif   (bus)
    );

    always #5 clock = ~clock;

    int n_tot  = 0;
    int n_pass = 0;
    int words  = 0;
    int starts = 0;
    int low_run = 0;
    int last_gap = -1;
    int idx_exp = 0;
    bit seen_frame = 0;
    bit prev_start = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor / scoreboard consumer, sampled on the falling edge
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            idx_exp    = 0;
            prev_start = 0;
            seen_frame = 0;
            low_run    = 0;
        end else begin
            if (prev_start) chk("dv_after_start", bus.xn_dv, 1);
            prev_start = bus.fft_start;
            if (bus.fft_start) starts++;
            if (bus.xn_dv) begin
                if (low_run > 0 && seen_frame) last_gap = low_run;
                low_run    = 0;
                seen_frame = 1;
                chk("scoreboard_has_word", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("xn", bus.xn, exp_q.pop_front());
                chk("xn_index", bus.xn_index, idx_exp);
                chk("xn_last", bus.xn_last, idx_exp == 63);
                idx_exp = (idx_exp + 1) % 64;
                words++;
            end else begin
                low_run++;
                chk("idle_index", bus.xn_index, 0);
                chk("idle_last", bus.xn_last, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ctrl(input logic [7:0] a, input logic [31:0] d);
        bus.set_stb  = 1'b1;
        bus.set_addr = a;
        bus.set_data = d;
        tick();
        bus.set_stb  = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input bit exp_push, input int gap);
        bus.sample_in  = v;
        bus.sample_stb = 1'b1;
        if (exp_push) exp_q.push_back(v);
        tick();
        bus.sample_stb = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic wait_words(input string tag, input int target, input int budget);
        int c = 0;
        while (words < target && c < budget) begin
            tick();
            c++;
        end
        chk(tag, words >= target, 1);
    endtask

    task automatic wait_idx(input string tag, input int idx);
        int c = 0;
        while (!(bus.xn_dv && bus.xn_index == 6'(idx)) && c < 300) begin
            tick();
            c++;
        end
        chk(tag, bus.xn_dv && bus.xn_index == 6'(idx), 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_start"}, bus.fft_start, 0);
        chk({tag, "_xn"}, bus.xn, 0);
        chk({tag, "_dv"}, bus.xn_dv, 0);
        chk({tag, "_idx"}, bus.xn_index, 0);
        chk({tag, "_last"}, bus.xn_last, 0);
        chk({tag, "_ovf"}, bus.overflow, 0);
        chk({tag, "_ovfcnt"}, bus.ovf_count, 0);
    endtask

    initial begin
        int w0;
        bus.set_stb    = 1'b0;
        bus.set_addr   = '0;
        bus.set_data   = '0;
        bus.sample_in  = '0;
        bus.sample_stb = 1'b0;
        bus.fft_rfd    = 1'b0;

        // T1: reset, strobes with enable off
        for (int i = 0; i < 10; i++) send(32'(i), 0, 1);
        chk_outputs_zero("t1_in_reset");
        reset = 1'b0;
        bus.fft_rfd = 1'b1;
        for (int i = 0; i < 70; i++) send(32'(i), 0, 1);
        repeat (20) tick();
        chk_outputs_zero("t1_after");
        chk("t1_no_start", starts, 0);

        // T2: basic frame, paced input; write to another address is ignored
        set_ctrl(8'd1, 32'd1);
        set_ctrl(8'd2, 32'd0);
        for (int i = 0; i < 64; i++) send(32'(i), 1, 3);
        wait_words("t2_frame_done", 64, 400);
        chk("t2_starts", starts, 1);
        chk("t2_sb_empty", exp_q.size(), 0);

        // T3: backpressure, then two back-to-back frames
        bus.fft_rfd = 1'b0;
        for (int i = 0; i < 128; i++) send(32'(100 + i), 1, 1);
        repeat (20) tick();
        chk("t3_held", starts, 1);
        bus.fft_rfd = 1'b1;
        wait_words("t3_frames_done", 192, 400);
        chk("t3_starts", starts, 3);
        chk("t3_gap", last_gap, 2);

        // T4: overflow
        bus.fft_rfd = 1'b0;
        chk("t4_ovf_before", bus.overflow, 0);
        for (int i = 0; i < 260; i++) send(32'(1000 + i), i < 256, 1);
        chk("t4_overflow", bus.overflow, 1);
        chk("t4_ovf_count", bus.ovf_count, 4);
        bus.fft_rfd = 1'b1;
        wait_words("t4_frames_done", 448, 1000);
        chk("t4_starts", starts, 7);
        chk("t4_ovf_sticky", bus.overflow, 1);

        // T5: flush during STREAM
        w0 = words;
        for (int i = 0; i < 64; i++) send(32'(2000 + i), 1, 1);
        wait_idx("t5_word10", 10);
        set_ctrl(8'd1, 32'd3);
        for (int i = 0; i < 20; i++) send(32'(3000 + i), 0, 1);
        wait_words("t5_frame_done", w0 + 64, 200);
        repeat (3) tick();
        chk("t5_ovf_cleared", bus.overflow, 0);
        chk("t5_ovfcnt_cleared", bus.ovf_count, 0);
        for (int i = 0; i < 44; i++) send(32'(4000 + i), 0, 1);
        repeat (60) tick();
        chk("t5_no_start", starts, 8);
        set_ctrl(8'd1, 32'd3);   // discard the partial fill
        repeat (3) tick();

        // T6: asynchronous reset mid-STREAM
        for (int i = 0; i < 64; i++) send(32'(5000 + i), 1, 1);
        wait_idx("t6_word20", 20);
        reset = 1'b1;
        #1;
        chk("t6_dv_async", bus.xn_dv, 0);
        chk("t6_start_async", bus.fft_start, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_outputs_zero("t6_after");
        for (int i = 0; i < 64; i++) send(32'(6000 + i), 0, 1);
        repeat (20) tick();
        chk("t6_enable_cleared", starts, 9);
        set_ctrl(8'd1, 32'd1);
        for (int i = 0; i < 63; i++) send(32'(7000 + i), 1, 1);
        repeat (20) tick();
        chk("t6_fifo_was_empty", starts, 9);
        w0 = words;
        send(32'd7063, 1, 1);
        wait_words("t6_frame_done", w0 + 64, 200);
        chk("t6_starts", starts, 10);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
